// File: rtl/jpeg_huff_pkg.sv
// Shared types, widths and JPEG DC Huffman tables for the DC symbol decoder.
// Holds the decoder state enum, luma/chroma code tables, max code lengths,
// and the helper that turns a raw magnitude field into a signed DC difference.
package jpeg_huff_pkg;

  localparam int CODE_W  = 11;  // code and magnitude register width
  localparam int SIZE_W  = 4;   // category width
  localparam int VALUE_W = 12;  // DC difference width
  localparam int LEN_W   = 4;   // code length counter width
  localparam int NUM_CAT = 12;  // categories 0..11

  localparam logic [LEN_W-1:0] LUMA_MAX_LEN   = 4'd9;
  localparam logic [LEN_W-1:0] CHROMA_MAX_LEN = 4'd11;

  // All-ones prefix of max length: no valid code starts this way
  localparam logic [CODE_W-1:0] LUMA_INVALID_CODE   = 11'h1FF;
  localparam logic [CODE_W-1:0] CHROMA_INVALID_CODE = 11'h7FF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CODE = 2'd1,
    ST_MAG  = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  // Code values are right-aligned; index is the category
  localparam logic [CODE_W-1:0] LUMA_DC_CODE [0:NUM_CAT-1] = '{
    11'd0,   11'd2,   11'd3,   11'd4,   11'd5,   11'd6,
    11'd14,  11'd30,  11'd62,  11'd126, 11'd254, 11'd510
  };
  localparam logic [LEN_W-1:0] LUMA_DC_LEN [0:NUM_CAT-1] = '{
    4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3,
    4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9
  };

  localparam logic [CODE_W-1:0] CHROMA_DC_CODE [0:NUM_CAT-1] = '{
    11'd0,   11'd1,   11'd2,   11'd6,   11'd14,  11'd30,
    11'd62,  11'd126, 11'd254, 11'd510, 11'd1022, 11'd2046
  };
  localparam logic [LEN_W-1:0] CHROMA_DC_LEN [0:NUM_CAT-1] = '{
    4'd2, 4'd2, 4'd2, 4'd3, 4'd4,  4'd5,
    4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11
  };

  // A leading 1 means a positive value equal to m; a leading 0 means the
  // negative range, recovered as m - (2^size - 1).
  function automatic logic [VALUE_W-1:0] dc_value_calc(
    input logic [CODE_W-1:0] m,
    input logic [SIZE_W-1:0] size
  );
    logic [VALUE_W-1:0] m_ext;
    logic [VALUE_W-1:0] bias;
    m_ext = {1'b0, m};
    bias  = (12'd1 << size) - 12'd1;
    if (size == '0) begin
      dc_value_calc = '0;
    end else if (m[size - 4'd1]) begin
      dc_value_calc = m_ext;
    end else begin
      dc_value_calc = m_ext - bias;
    end
  endfunction

endpackage

// File: rtl/dc_code_match.sv
// Combinational DC code lookup against the luma or chroma table.
// Latency: 0 cycles. Backpressure: none (pure lookup).
// Ports: is_luminance/code/length in; hit (code matched), size (category),
//        invalid (max-length all-ones prefix) out.
module dc_code_match
  import jpeg_huff_pkg::*;
(
  input  logic              is_luminance,
  input  logic [CODE_W-1:0] code,
  input  logic [LEN_W-1:0]  length,
  output logic              hit,
  output logic [SIZE_W-1:0] size,
  output logic              invalid
);

  // Tables are prefix-free, so at most one entry can match
  always_comb begin
    hit  = 1'b0;
    size = '0;
    for (int i = 0; i < NUM_CAT; i++) begin
      if (is_luminance) begin
        if (length == LUMA_DC_LEN[i] && code == LUMA_DC_CODE[i]) begin
          hit  = 1'b1;
          size = SIZE_W'(i);
        end
      end else begin
        if (length == CHROMA_DC_LEN[i] && code == CHROMA_DC_CODE[i]) begin
          hit  = 1'b1;
          size = SIZE_W'(i);
        end
      end
    end
  end

  always_comb begin
    if (is_luminance) begin
      invalid = (length == LUMA_MAX_LEN) && (code == LUMA_INVALID_CODE);
    end else begin
      invalid = (length == CHROMA_MAX_LEN) && (code == CHROMA_INVALID_CODE);
    end
  end

endmodule

// File: rtl/huffman_dc_dec.sv
// Serial JPEG DC symbol decoder: Huffman category code, then size magnitude bits.
// Latency: L+s bit transfers after start, result valid the cycle after the last bit.
// Backpressure: bit_valid=0 stalls in place; out_ready=0 holds the result in OUT.
// Ports: start/is_luminance begin a symbol; bit_in/bit_valid/bit_ready carry the
//        serial stream; out_valid/out_ready hand off dc_size/dc_value/err.
module huffman_dc_dec
  import jpeg_huff_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_luminance,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SIZE_W-1:0]  dc_size,
  output logic [VALUE_W-1:0] dc_value,
  output logic               err
);

  state_e              r_state;
  logic                r_luma;
  logic [CODE_W-1:0]   r_code;
  logic [LEN_W-1:0]    r_len;
  logic [CODE_W-1:0]   r_mag;
  logic [SIZE_W-1:0]   r_mcnt;
  logic [SIZE_W-1:0]   r_size;
  logic                r_bit_ready;
  logic                r_out_valid;
  logic                r_err;
  logic [SIZE_W-1:0]   r_dc_size;
  logic [VALUE_W-1:0]  r_dc_value;

  logic                w_xfer;
  logic [CODE_W-1:0]   w_code_nxt;
  logic [LEN_W-1:0]    w_len_nxt;
  logic [CODE_W-1:0]   w_mag_nxt;
  logic                w_mag_last;
  logic                w_hit;
  logic [SIZE_W-1:0]   w_size;
  logic                w_invalid;

  // bit_ready is only ever high in CODE/MAG, so a transfer implies one of those
  assign w_xfer     = bit_valid & r_bit_ready;
  // Match against the code including the bit arriving this cycle, so the
  // decision is made on the same edge that accepts the final code bit
  assign w_code_nxt = {r_code[CODE_W-2:0], bit_in};
  assign w_len_nxt  = r_len + 4'd1;
  assign w_mag_nxt  = {r_mag[CODE_W-2:0], bit_in};
  assign w_mag_last = (r_mcnt == r_size - 4'd1);

  dc_code_match u_match (
    .is_luminance (r_luma),
    .code         (w_code_nxt),
    .length       (w_len_nxt),
    .hit          (w_hit),
    .size         (w_size),
    .invalid      (w_invalid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_luma      <= 1'b0;
      r_code      <= '0;
      r_len       <= '0;
      r_mag       <= '0;
      r_mcnt      <= '0;
      r_size      <= '0;
      r_bit_ready <= 1'b0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_dc_size   <= '0;
      r_dc_value  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_CODE;
            r_luma      <= is_luminance;
            r_code      <= '0;
            r_len       <= '0;
            r_mag       <= '0;
            r_mcnt      <= '0;
            r_size      <= '0;
            r_bit_ready <= 1'b1;
          end
        end

        ST_CODE: begin
          if (w_xfer) begin
            r_code <= w_code_nxt;
            r_len  <= w_len_nxt;
            if (w_hit && w_size != '0) begin
              r_state <= ST_MAG;
              r_size  <= w_size;
            end else if (w_hit || w_invalid) begin
              // Category 0 or a bad prefix: no magnitude field follows
              r_state     <= ST_OUT;
              r_bit_ready <= 1'b0;
              r_out_valid <= 1'b1;
              r_err       <= w_invalid;
              r_dc_size   <= '0;
              r_dc_value  <= '0;
            end
          end
        end

        ST_MAG: begin
          if (w_xfer) begin
            r_mag  <= w_mag_nxt;
            r_mcnt <= r_mcnt + 4'd1;
            if (w_mag_last) begin
              r_state     <= ST_OUT;
              r_bit_ready <= 1'b0;
              r_out_valid <= 1'b1;
              r_err       <= 1'b0;
              r_dc_size   <= r_size;
              r_dc_value  <= dc_value_calc(w_mag_nxt, r_size);
            end
          end
        end

        ST_OUT: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_bit_ready <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bit_ready = r_bit_ready;
  assign out_valid = r_out_valid;
  assign dc_size   = r_dc_size;
  assign dc_value  = r_dc_value;
  assign err       = r_err;

endmodule

// File: tb/tb_huffman_dc_dec.sv
// Directed bench for huffman_dc_dec: each scenario task drives a symbol and
// checks the decoded result against hand-computed values.
module tb_huffman_dc_dec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_luminance;
  logic        bit_in;
  logic        bit_valid;
  logic        out_ready;
  logic        bit_ready;
  logic        out_valid;
  logic [3:0]  dc_size;
  logic [11:0] dc_value;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  huffman_dc_dec dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .is_luminance (is_luminance),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .dc_size      (dc_size),
    .dc_value     (dc_value),
    .err          (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a symbol, feeds the n-bit vector MSB-first until out_valid rises.
  // cyc_out is the cycle (start accepted = cycle 0) in which out_valid is seen,
  // or -1 on timeout. gappy toggles bit_valid every other cycle.
  task automatic drive_symbol(input logic luma, input logic [31:0] bits, input int n,
                              input bit gappy, output int cyc_out, output int consumed);
    int  idx;
    int  cyc;
    bit  xfer;
    idx          = 0;
    is_luminance = luma;
    start        = 1'b1;
    bit_valid    = 1'b0;
    step();
    start        = 1'b0;
    is_luminance = 1'b0;
    cyc          = 1;
    while (out_valid !== 1'b1 && cyc < 200) begin
      if (idx < n) begin
        bit_in    = bits[n-1-idx];
        bit_valid = gappy ? cyc[0] : 1'b1;
      end else begin
        bit_in    = 1'b0;
        bit_valid = 1'b0;
      end
      xfer = (bit_valid === 1'b1) && (bit_ready === 1'b1);
      step();
      if (xfer) idx++;
      cyc++;
    end
    bit_valid = 1'b0;
    cyc_out   = (out_valid === 1'b1) ? cyc : -1;
    consumed  = idx;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; is_luminance = 1'b0; bit_in = 1'b0;
    bit_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    checks++; if (bit_ready !== 1'b0) begin errors++; $display("FAIL reset_bit_ready got %b exp 0", bit_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (dc_size !== 4'd0) begin errors++; $display("FAIL reset_dc_size got %0d exp 0", dc_size); end
    checks++; if (dc_value !== 12'h000) begin errors++; $display("FAIL reset_dc_value got %h exp 000", dc_value); end
    rst_n = 1'b1;
    step(); step();
    checks++; if (bit_ready !== 1'b0) begin errors++; $display("FAIL idle_bit_ready got %b exp 0", bit_ready); end
  endtask

  task automatic test_luma_pos();
    int cyc, used;
    drive_symbol(1'b1, 32'b01110, 5, 1'b0, cyc, used);
    checks++; if (cyc != 6) begin errors++; $display("FAIL luma_pos_cycle got %0d exp 6", cyc); end
    checks++; if (dc_size !== 4'd2) begin errors++; $display("FAIL luma_pos_size got %0d exp 2", dc_size); end
    checks++; if (dc_value !== 12'h002) begin errors++; $display("FAIL luma_pos_value got %h exp 002", dc_value); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL luma_pos_err got %b exp 0", err); end
    checks++; if (bit_ready !== 1'b0) begin errors++; $display("FAIL luma_pos_ready_out got %b exp 0", bit_ready); end
    release_out();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL luma_pos_release got %b exp 0", out_valid); end
  endtask

  task automatic test_luma_neg();
    int cyc, used;
    drive_symbol(1'b1, 32'b100010, 6, 1'b0, cyc, used);
    checks++; if (cyc != 7) begin errors++; $display("FAIL luma_neg_cycle got %0d exp 7", cyc); end
    checks++; if (dc_size !== 4'd3) begin errors++; $display("FAIL luma_neg_size got %0d exp 3", dc_size); end
    checks++; if (dc_value !== 12'hFFB) begin errors++; $display("FAIL luma_neg_value got %h exp ffb", dc_value); end
    release_out();
  endtask

  task automatic test_luma_zero();
    int cyc, used;
    drive_symbol(1'b1, 32'b0011, 4, 1'b0, cyc, used);
    checks++; if (cyc != 3) begin errors++; $display("FAIL luma_zero_cycle got %0d exp 3", cyc); end
    checks++; if (used != 2) begin errors++; $display("FAIL luma_zero_consumed got %0d exp 2", used); end
    checks++; if (dc_size !== 4'd0) begin errors++; $display("FAIL luma_zero_size got %0d exp 0", dc_size); end
    checks++; if (dc_value !== 12'h000) begin errors++; $display("FAIL luma_zero_value got %h exp 000", dc_value); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL luma_zero_err got %b exp 0", err); end
    release_out();
  endtask

  task automatic test_chroma_max();
    int cyc, used;
    // 11111111110 then eleven zeros
    drive_symbol(1'b0, 32'h003FF000, 22, 1'b0, cyc, used);
    checks++; if (cyc != 23) begin errors++; $display("FAIL chroma_max_cycle got %0d exp 23", cyc); end
    checks++; if (dc_size !== 4'd11) begin errors++; $display("FAIL chroma_max_size got %0d exp 11", dc_size); end
    checks++; if (dc_value !== 12'h801) begin errors++; $display("FAIL chroma_max_value got %h exp 801", dc_value); end
    release_out();
  endtask

  task automatic test_luma_err();
    int cyc, used;
    int bad;
    drive_symbol(1'b1, 32'hFFF, 12, 1'b0, cyc, used);
    checks++; if (cyc != 10) begin errors++; $display("FAIL err_cycle got %0d exp 10", cyc); end
    checks++; if (used != 9) begin errors++; $display("FAIL err_consumed got %0d exp 9", used); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_flag got %b exp 1", err); end
    checks++; if (dc_size !== 4'd0) begin errors++; $display("FAIL err_size got %0d exp 0", dc_size); end
    checks++; if (dc_value !== 12'h000) begin errors++; $display("FAIL err_value got %h exp 000", dc_value); end
    // Keep offering ones: none may be accepted
    bad = 0;
    bit_in = 1'b1; bit_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bit_ready !== 1'b0) bad++;
      step();
    end
    bit_valid = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL err_ready_after got %0d high cycles exp 0", bad); end
    release_out();
    step();
    checks++; if (bit_ready !== 1'b0) begin errors++; $display("FAIL err_idle_ready got %b exp 0", bit_ready); end
  endtask

  task automatic test_backpressure();
    int cyc, used;
    int bad;
    drive_symbol(1'b1, 32'b01110, 5, 1'b1, cyc, used);
    checks++; if (cyc < 7) begin errors++; $display("FAIL bp_cycle got %0d exp >=7", cyc); end
    checks++; if (dc_size !== 4'd2 || dc_value !== 12'h002 || err !== 1'b0) begin
      errors++; $display("FAIL bp_result got size %0d value %h err %b exp 2 002 0", dc_size, dc_value, err);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);  // a start in OUT must be ignored
      is_luminance = 1'b1;
      step();
      if (out_valid !== 1'b1 || bit_ready !== 1'b0 || dc_size !== 4'd2 ||
          dc_value !== 12'h002 || err !== 1'b0) bad++;
    end
    start = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles exp 0", bad); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int cyc, used;
    drive_symbol(1'b0, 32'b011, 3, 1'b0, cyc, used);
    checks++; if (cyc != 4 || dc_size !== 4'd1 || dc_value !== 12'h001) begin
      errors++; $display("FAIL b2b_first got cyc %0d size %0d value %h exp 4 1 001", cyc, dc_size, dc_value);
    end
    release_out();
    drive_symbol(1'b0, 32'b1001, 4, 1'b0, cyc, used);
    checks++; if (cyc != 5 || dc_size !== 4'd2 || dc_value !== 12'hFFE) begin
      errors++; $display("FAIL b2b_second got cyc %0d size %0d value %h exp 5 2 ffe", cyc, dc_size, dc_value);
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    logic [3:0] pat;
    int cyc, used;
    pat = 4'b0111;  // luma cat2 code then one magnitude bit
    is_luminance = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      bit_in = pat[i]; bit_valid = 1'b1;
      step();
    end
    bit_valid = 1'b0;
    checks++; if (bit_ready !== 1'b1) begin errors++; $display("FAIL mid_in_mag got %b exp 1", bit_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bit_ready !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0 ||
                  dc_size !== 4'd0 || dc_value !== 12'h000) begin
      errors++; $display("FAIL mid_reset got rdy %b vld %b err %b size %0d value %h exp all 0",
                         bit_ready, out_valid, err, dc_size, dc_value);
    end
    step();
    rst_n = 1'b1;
    bit_in = 1'b1; bit_valid = 1'b1;
    step(); step();
    bit_valid = 1'b0;
    checks++; if (bit_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_idle got rdy %b vld %b exp 0 0", bit_ready, out_valid);
    end
    drive_symbol(1'b1, 32'b01110, 5, 1'b0, cyc, used);
    checks++; if (cyc != 6 || dc_value !== 12'h002) begin
      errors++; $display("FAIL mid_recover got cyc %0d value %h exp 6 002", cyc, dc_value);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_luma_pos();
    test_luma_neg();
    test_luma_zero();
    test_chroma_max();
    test_luma_err();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/huffman_dc_dec.md
HUFFMAN_DC_DEC -- requirements
Module: huffman_dc_dec

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: begin decoding one DC symbol; honoured only in IDLE.
REQ-004 SHALL have port is_luminance, input, 1 bit: table select, 1 = luma (JPEG K.3), 0 = chroma (K.4); sampled only when start is accepted.
REQ-005 SHALL have port bit_in, input, 1 bit: serial coded bit, MSB-first.
REQ-006 SHALL have port bit_valid, input, 1 bit: bit_in is valid.
REQ-007 SHALL have port bit_ready, output, 1 bit: decoder accepts bit_in; a bit transfers when bit_valid and bit_ready are both 1.
REQ-008 SHALL have port out_valid, output, 1 bit: dc_size, dc_value and err are valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port dc_size, output, 4 bits: decoded category, 0..11.
REQ-011 SHALL have port dc_value, output, 12 bits: decoded DC difference, two's complement.
REQ-012 SHALL have port err, output, 1 bit: invalid Huffman code; valid only when out_valid=1.

Function
REQ-013 SHALL implement FSM states IDLE, CODE, MAG, OUT.
- IDLE -> CODE on start.
- CODE -> MAG on a code match with size>0.
- CODE -> OUT on a match with size=0, or on an invalid prefix.
- MAG -> OUT when the size-th magnitude bit transfers.
- OUT -> IDLE on out_ready.
REQ-014 SHALL assert bit_ready only in CODE and MAG; bit_ready SHALL be registered.
REQ-015 In CODE, each transferred bit SHALL be shifted into an 11-bit code register and SHALL increment a 4-bit length counter. The code register and length counter SHALL be compared combinationally against the selected table in the same cycle.
REQ-016 Luma codes:
- cat0 = 00; cat1..5 = 010, 011, 100, 101, 110
- cat6 = 1110, cat7 = 11110, cat8 = 111110, cat9 = 1111110, cat10 = 11111110, cat11 = 111111110.
REQ-017 Chroma codes:
- cat0 = 00, cat1 = 01, cat2 = 10
- cat3..11 = n ones followed by 0, for n = 2..10.
REQ-018 An invalid prefix SHALL be 9 consecutive ones (luma) or 11 consecutive ones (chroma). On an invalid prefix:
- FSM SHALL go to OUT with err=1, dc_size=0, dc_value=0.
- No further bits SHALL be consumed.
REQ-019 In MAG, exactly dc_size bits SHALL be shifted MSB-first into an 11-bit magnitude register m.
REQ-020 dc_value SHALL be computed as follows:
- if the first magnitude bit is 1: dc_value = +m (zero-extended);
- otherwise: dc_value = m - (2^size - 1) (sign-extended to 12 bits);
- size 0: dc_value = 0.
REQ-021 dc_size, dc_value and err SHALL be registered. out_valid SHALL rise the cycle after the final code or magnitude bit transfers.
REQ-022 Outputs SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 With bit_valid held 1, a symbol with code length L and size s SHALL take L+s cycles in CODE/MAG. Start is accepted in cycle 0, so out_valid=1 in cycle L+s+1.
REQ-024 start asserted outside IDLE SHALL be ignored.
REQ-025 bit_valid=0 SHALL stall CODE/MAG with no state change.
REQ-026 In OUT, out_ready=1 SHALL return the FSM to IDLE. A start in the cycle immediately after is accepted; there is no back-to-back shortcut.

Reset
REQ-027 rst_n=0 SHALL asynchronously force:
- FSM = IDLE
- bit_ready = 0, out_valid = 0, err = 0
- dc_size = 0, dc_value = 0
- code, length and magnitude registers = 0
REQ-028 Reset asserted mid-symbol SHALL discard the partial symbol. After rst_n=1, the block SHALL wait in IDLE for start.

Structure
REQ-029 Package jpeg_huff_pkg SHALL hold:
- the state enum;
- the luma and chroma DC code/length tables;
- max code lengths (luma 9, chroma 11);
- width constants: code 11, size 4, value 12.
REQ-030 Sub-module dc_code_match SHALL be a combinational lookup with:
- inputs: is_luminance, code, length;
- outputs: hit, size, invalid.
It SHALL be instantiated once.
REQ-031 Target implementation size: 120-400 lines of RTL.

Verification
REQ-032 Luma, bits 011,10 -> dc_size=2, dc_value=+2, err=0; out_valid in cycle 6.
REQ-033 Luma, bits 100,010 -> dc_size=3, dc_value=-5 (0xFFB).
REQ-034 Luma, bits 00 -> dc_size=0, dc_value=0, out_valid in cycle 3, no magnitude bits consumed.
REQ-035 Chroma, bits 11111111110 + eleven 0s -> dc_size=11, dc_value=-2047 (0x801).
REQ-036 Luma, nine 1s -> err=1, dc_size=0, and bit_ready=0 thereafter until the next start.
REQ-037 Backpressure and reset:
- bit_valid toggled 1/0 and out_ready=0 for 5 cycles -> same result, outputs held stable, bit_ready=0 in OUT;
- rst_n pulsed mid-MAG -> all outputs 0, FSM in IDLE.
